// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Purpose : AHB encodings shared by the master interface, the master arbiter
//           and the AHB-to-APB bridge.
// Contents: HTRANS_* transfer-type codes, HRESP_OKAY response code.
// ---------------------------------------------------------------------------
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HRESP_OKAY    = 2'd0;

endpackage

// File: rtl/ahb_rr_pick.sv
// ---------------------------------------------------------------------------
// ahb_rr_pick
// Purpose : Combinational round-robin selector. Searches the request vector
//           starting at i_last+1, wrapping modulo N_MASTERS, and visits i_last
//           itself last.
// Ports   : i_req   - per-master request vector
//           i_last  - index of the current/last owner
//           o_idx   - first requesting index found (i_last when none)
//           o_valid - at least one request was found
// ---------------------------------------------------------------------------
module ahb_rr_pick #(
  parameter int N_MASTERS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_valid
);

  // w_cand[k] is the master visited at search offset k+1 from i_last.
  // One extra bit holds the unwrapped sum, which never exceeds 2*N_MASTERS-1.
  logic [IDX_W:0] w_cand [N_MASTERS];

  generate
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_cand
      logic [IDX_W:0] w_sum;
      assign w_sum = {1'b0, i_last} + (IDX_W+1)'(gi + 1);
      assign w_cand[gi] = (w_sum >= (IDX_W+1)'(N_MASTERS))
                        ? (w_sum - (IDX_W+1)'(N_MASTERS))
                        : w_sum;
    end
  endgenerate

  // Walk from the farthest offset down to the nearest so the nearest
  // requesting master overwrites any earlier hit.
  always_comb begin
    o_idx   = i_last;
    o_valid = 1'b0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (i_req[w_cand[k][IDX_W-1:0]]) begin
        o_idx   = w_cand[k][IDX_W-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_master_arbiter
// Purpose : Shares the single AHB slave port of the AHB-to-APB bridge between
//           N_MASTERS masters. Address phase is granted round-robin to one
//           master at a time; the data-phase owner is tracked separately so
//           pipelined write data comes from the master whose address phase
//           was accepted.
// Build option: define ARB_TENURE_EN to add a tenure counter that lets a
//           long-holding owner be preempted at a non-SEQ boundary once it has
//           held the bus for MAX_TENURE-1 cycles while others wait.
// Ports   :
//   Hclk, Hresetn          - clock, synchronous active-low reset
//   m_Hbusreq[N]           - per-master bus request
//   m_Haddr[32N]           - flattened master addresses (master i at [32i+:32])
//   m_Hwdata[32N]          - flattened master write data
//   m_Hwrite[N], m_Htrans[2N], m_Hready_in[N] - per-master control
//   m_Hgrant[N]            - registered one-hot grant
//   Hmaster[IDX_W]         - registered address-phase owner index
//   Haddr/Hwrite/Htrans/Hready_in - address-phase mux to the bridge
//   Hwdata                 - data-phase mux to the bridge
//   Hready_out, Hrdata, Hresp - bridge response, broadcast to all masters
// ---------------------------------------------------------------------------
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int N_MASTERS  = 2,
  parameter int IDX_W      = 1,
  parameter int MAX_TENURE = 16
) (
  input  logic                   Hclk,
  input  logic                   Hresetn,
  input  logic [N_MASTERS-1:0]   m_Hbusreq,
  input  logic [32*N_MASTERS-1:0] m_Haddr,
  input  logic [32*N_MASTERS-1:0] m_Hwdata,
  input  logic [N_MASTERS-1:0]   m_Hwrite,
  input  logic [2*N_MASTERS-1:0] m_Htrans,
  input  logic [N_MASTERS-1:0]   m_Hready_in,
  output logic [N_MASTERS-1:0]   m_Hgrant,
  output logic [IDX_W-1:0]       Hmaster,
  output logic [31:0]            Haddr,
  output logic [31:0]            Hwdata,
  output logic                   Hwrite,
  output logic [1:0]             Htrans,
  output logic                   Hready_in,
  input  logic                   Hready_out,
  input  logic [31:0]            Hrdata,
  input  logic [1:0]             Hresp
);

  // -------------------------------------------------------------------------
  // Per-master views of the flattened buses
  // -------------------------------------------------------------------------
  logic [31:0] w_addr_arr  [N_MASTERS];
  logic [31:0] w_wdata_arr [N_MASTERS];
  logic [1:0]  w_trans_arr [N_MASTERS];

  generate
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = m_Haddr[32*gi +: 32];
      assign w_wdata_arr[gi] = m_Hwdata[32*gi +: 32];
      assign w_trans_arr[gi] = m_Htrans[2*gi +: 2];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [N_MASTERS-1:0] r_grant;
  logic [IDX_W-1:0]     r_hmaster;
  logic [IDX_W-1:0]     r_hmaster_d;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic [1:0]           w_own_trans;
  logic                 w_own_req;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_valid;
  logic [N_MASTERS-1:0] w_pick_onehot;
  logic                 w_handover_std;
  logic                 w_tenure_hit;
  logic                 w_handover;

  assign w_own_trans = w_trans_arr[r_hmaster];
  assign w_own_req   = m_Hbusreq[r_hmaster];

  ahb_rr_pick #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .i_req   (m_Hbusreq),
    .i_last  (r_hmaster),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  generate
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_onehot
      assign w_pick_onehot[gi] = (w_pick_idx == IDX_W'(gi));
    end
  endgenerate

  // The owner may only be replaced when its current address phase completes
  // (Hready_out=1) and it is not in the middle of a transfer it still wants.
  assign w_handover_std = Hready_out &&
                          ((w_own_trans == HTRANS_IDLE) || !w_own_req);

`ifdef ARB_TENURE_EN
  localparam int TEN_W = $clog2(MAX_TENURE + 1);

  logic [TEN_W-1:0]     r_tenure;
  logic [N_MASTERS-1:0] w_other_reqs;
  logic                 w_others_req;
  logic                 w_switch;

  assign w_other_reqs = m_Hbusreq & ~r_grant;
  assign w_others_req = |w_other_reqs;

  // Once tenure is used up, any completed non-SEQ beat is a legal cut point;
  // SEQ beats stay protected so a burst is never split mid-way.
  assign w_tenure_hit = (r_tenure >= TEN_W'(MAX_TENURE - 1)) && Hready_out &&
                        (w_own_trans != HTRANS_SEQ);

  // Only a handover that actually moves the grant resets the tenure count;
  // re-picking the same owner is a park, not a change of ownership.
  assign w_switch = w_handover && w_pick_valid && (w_pick_idx != r_hmaster);

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      r_tenure <= '0;
    end else if (w_switch) begin
      r_tenure <= '0;
    end else if (w_others_req && (r_tenure != TEN_W'(MAX_TENURE))) begin
      r_tenure <= r_tenure + TEN_W'(1);
    end
  end
`else
  localparam int UNUSED_MAX_TENURE = MAX_TENURE;

  assign w_tenure_hit = 1'b0;
`endif

  assign w_handover = w_handover_std || w_tenure_hit;

  // -------------------------------------------------------------------------
  // Grant / owner registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      r_grant     <= N_MASTERS'(1);
      r_hmaster   <= '0;
      r_hmaster_d <= '0;
    end else begin
      // No requester at a handover point: grant parks on the current owner.
      if (w_handover && w_pick_valid) begin
        r_grant   <= w_pick_onehot;
        r_hmaster <= w_pick_idx;
      end
      // The address phase accepted on this edge belongs to r_hmaster; its
      // data phase follows on the next cycle.
      if (Hready_out) begin
        r_hmaster_d <= r_hmaster;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Muxes to the bridge
  // -------------------------------------------------------------------------
  assign m_Hgrant  = r_grant;
  assign Hmaster   = r_hmaster;
  assign Haddr     = w_addr_arr[r_hmaster];
  assign Hwrite    = m_Hwrite[r_hmaster];
  assign Htrans    = w_trans_arr[r_hmaster];
  assign Hready_in = m_Hready_in[r_hmaster];
  assign Hwdata    = w_wdata_arr[r_hmaster_d];

  // Read data and response go straight from the bridge to every master;
  // the arbiter never inspects them.
  logic w_unused_bcast;
  assign w_unused_bcast = ^{Hrdata, Hresp};

endmodule
